// File: rtl/keygen_sequencer.sv
// Dilithium3 (K=6, L=5) key generation stage sequencer.
// Pulses sub-block starts, gathers dones, runs a watchdog and a run timer.
module keygen_sequencer #(
  parameter int FINAL_CYCLES = 2,
  parameter int TIMEOUT      = 100000,
  parameter int CW           = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_keygen,
  output logic          done_keygen,
  output logic          busy,
  output logic          error,
  output logic [3:0]    stage,
  output logic [3:0]    err_stage,
  output logic [CW-1:0] cycle_count,
  output logic          start_shake_1,
  input  logic          done_shake_1,
  output logic          start_polyvecl_uniform_eta,
  input  logic          done_polyvecl_uniform_eta,
  output logic          start_polyveck_uniform_eta,
  input  logic          done_polyveck_uniform_eta,
  output logic          start_polyvec_matrix_expand,
  input  logic          done_polyvec_matrix_expand,
  output logic          start_polyvecl_ntt,
  input  logic          done_polyvecl_ntt,
  output logic          start_polyvec_matrix_pointwise_montgomery,
  input  logic          done_polyvec_matrix_pointwise_montgomery,
  output logic          start_polyveck_invntt,
  input  logic          done_polyveck_invntt,
  output logic          t_load_en,
  output logic          start_shake_2,
  input  logic          done_shake_2
);

  // Stage counter must hold both the watchdog limit and the FINAL length.
  localparam int LIM =
    (TIMEOUT > FINAL_CYCLES) ? TIMEOUT : FINAL_CYCLES;
  localparam int WW = (LIM > 1) ? $clog2(LIM + 1) : 1;
  localparam logic [WW-1:0] WD_TMO = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_FIN = WW'(FINAL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SHAKE1 = 4'd1,
    S_EXPAND = 4'd2,
    S_NTT    = 4'd3,
    S_MATMUL = 4'd4,
    S_INVNTT = 4'd5,
    S_FINAL  = 4'd6,
    S_SHAKE2 = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd15
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          first;
  logic [2:0]    flags;
  logic [2:0]    dv;
  logic [2:0]    req;
  logic [2:0]    seen;
  logic [WW-1:0] wd;
  logic          start_prev;
  logic          edge_seen;
  logic          idle_like;
  logic          watched;
  logic          complete;
  logic          tmo;
  logic [3:0]    err_n;

  assign edge_seen = start_keygen & ~start_prev;
  assign idle_like = (state == S_IDLE) ||
                     (state == S_DONE) ||
                     (state == S_ERROR);

  // Route the current stage's done inputs and required-flag mask.
  always_comb begin
    dv      = 3'b000;
    req     = 3'b000;
    watched = 1'b0;
    unique case (state)
      S_SHAKE1: begin
        dv      = {2'b00, done_shake_1};
        req     = 3'b001;
        watched = 1'b1;
      end
      S_EXPAND: begin
        dv      = {done_polyvec_matrix_expand,
                   done_polyveck_uniform_eta,
                   done_polyvecl_uniform_eta};
        req     = 3'b111;
        watched = 1'b1;
      end
      S_NTT: begin
        dv      = {2'b00, done_polyvecl_ntt};
        req     = 3'b001;
        watched = 1'b1;
      end
      S_MATMUL: begin
        dv      = {2'b00,
                   done_polyvec_matrix_pointwise_montgomery};
        req     = 3'b001;
        watched = 1'b1;
      end
      S_INVNTT: begin
        dv      = {2'b00, done_polyveck_invntt};
        req     = 3'b001;
        watched = 1'b1;
      end
      S_SHAKE2: begin
        dv      = {2'b00, done_shake_2};
        req     = 3'b001;
        watched = 1'b1;
      end
      default: begin
        dv      = 3'b000;
        req     = 3'b000;
        watched = 1'b0;
      end
    endcase
  end

  // Dones in the start-pulse cycle are stale and never count.
  assign seen     = (flags | dv) & req;
  assign complete = watched && !first && (seen == req);
  assign tmo      = (TIMEOUT != 0) && watched &&
                    (wd == WD_TMO);

  // Next state; completion beats a simultaneous timeout.
  always_comb begin
    state_n = state;
    err_n   = err_stage;
    if (edge_seen && idle_like) begin
      state_n = S_SHAKE1;
      err_n   = 4'd0;
    end else if (complete) begin
      unique case (state)
        S_SHAKE1: state_n = S_EXPAND;
        S_EXPAND: state_n = S_NTT;
        S_NTT:    state_n = S_MATMUL;
        S_MATMUL: state_n = S_INVNTT;
        S_INVNTT: state_n = S_FINAL;
        S_SHAKE2: state_n = S_DONE;
        default:  state_n = state;
      endcase
    end else if (tmo) begin
      state_n = S_ERROR;
      err_n   = state;
    end else if (state == S_FINAL && wd == WD_FIN) begin
      state_n = S_SHAKE2;
    end
  end

  // State, entry marker, start history and error code registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      first      <= 1'b0;
      start_prev <= 1'b0;
      err_stage  <= 4'd0;
    end else begin
      state      <= state_n;
      first      <= (state_n != state);
      start_prev <= start_keygen;
      err_stage  <= err_n;
    end
  end

  // Sticky done flags and the per-stage wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags <= 3'b000;
      wd    <= '0;
    end else if (state_n != state) begin
      flags <= 3'b000;
      wd    <= '0;
    end else begin
      if (!first) begin
        flags <= seen;
      end
      if (wd != '1) begin
        wd <= wd + WW'(1);
      end
    end
  end

  // Run timer, saturating, frozen outside the working stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (edge_seen && idle_like) begin
      cycle_count <= '0;
    end else if (busy && cycle_count != '1) begin
      cycle_count <= cycle_count + CW'(1);
    end
  end

  assign stage       = state;
  assign done_keygen = (state == S_DONE);
  assign error       = (state == S_ERROR);
  assign busy        = !idle_like;
  assign t_load_en   = (state == S_FINAL);

  assign start_shake_1 =
    first && (state == S_SHAKE1);
  assign start_polyvecl_uniform_eta =
    first && (state == S_EXPAND);
  assign start_polyveck_uniform_eta =
    first && (state == S_EXPAND);
  assign start_polyvec_matrix_expand =
    first && (state == S_EXPAND);
  assign start_polyvecl_ntt =
    first && (state == S_NTT);
  assign start_polyvec_matrix_pointwise_montgomery =
    first && (state == S_MATMUL);
  assign start_polyveck_invntt =
    first && (state == S_INVNTT);
  assign start_shake_2 =
    first && (state == S_SHAKE2);

endmodule

// File: tb/tb_keygen_sequencer.sv
// Bench for keygen_sequencer: randomized runs vs. a stage-timeline model.
// Done waveforms are planned up front; the model scans them per stage.
module tb_keygen_sequencer;

  localparam int FC   = 2;
  localparam int TMO  = 10;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int NMAX = 2400;
  localparam int NB   = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_keygen = 1'b0;
  logic          done_keygen;
  logic          busy;
  logic          error;
  logic          t_load_en;
  logic [3:0]    stage;
  logic [3:0]    err_stage;
  logic [CW-1:0] cycle_count;
  wire  [NB-1:0] st;
  logic [NB-1:0] dn = '0;

  keygen_sequencer #(
    .FINAL_CYCLES(FC),
    .TIMEOUT(TMO),
    .CW(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_keygen(start_keygen),
    .done_keygen(done_keygen),
    .busy(busy),
    .error(error),
    .stage(stage),
    .err_stage(err_stage),
    .cycle_count(cycle_count),
    .start_shake_1(st[0]),
    .done_shake_1(dn[0]),
    .start_polyvecl_uniform_eta(st[1]),
    .done_polyvecl_uniform_eta(dn[1]),
    .start_polyveck_uniform_eta(st[2]),
    .done_polyveck_uniform_eta(dn[2]),
    .start_polyvec_matrix_expand(st[3]),
    .done_polyvec_matrix_expand(dn[3]),
    .start_polyvecl_ntt(st[4]),
    .done_polyvecl_ntt(dn[4]),
    .start_polyvec_matrix_pointwise_montgomery(st[5]),
    .done_polyvec_matrix_pointwise_montgomery(dn[5]),
    .start_polyveck_invntt(st[6]),
    .done_polyveck_invntt(dn[6]),
    .t_load_en(t_load_en),
    .start_shake_2(st[7]),
    .done_shake_2(dn[7])
  );

  always #5 clock = ~clock;

  bit            in_start [NMAX];
  bit            in_rst   [NMAX];
  bit            wave     [NB][NMAX];
  logic [3:0]    ex_stage [NMAX];
  logic [3:0]    ex_err   [NMAX];
  int            ex_cc    [NMAX];
  logic [NB-1:0] ex_st    [NMAX];
  bit            ex_tl    [NMAX];

  int         dly  [NB];
  bit         lvl  [NB];
  int         hold [NB];
  int         ent  [8];
  bit         force_sp;
  logic [3:0] h_stage;
  logic [3:0] h_err;
  int         h_cc;
  int         n_cyc;
  int         cur;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h",
               tag, cur, got, want);
    end
  endtask

  function automatic int blo(input int s);
    case (s)
      1: return 0;
      2: return 1;
      3: return 4;
      4: return 5;
      5: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic int bhi(input int s);
    return (s == 2) ? 3 : blo(s);
  endfunction

  function automatic logic [NB-1:0] mask(input int s);
    logic [NB-1:0] m;
    m = '0;
    for (int b = blo(s); b <= bhi(s); b++) m[b] = 1'b1;
    return m;
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic void put(input int b, input int c);
    if (c < NMAX) wave[b][c] = 1'b1;
  endfunction

  function automatic bit is_edge(input int c);
    bit prev;
    prev = (c == 0 || in_rst[c-1]) ? 1'b0 : in_start[c-1];
    return in_start[c] && !prev;
  endfunction

  function automatic void wr(input int c, input int c0, input int s,
                             input logic [NB-1:0] m, input bit tl);
    ex_stage[c] = 4'(s);
    ex_err[c]   = 4'd0;
    ex_cc[c]    = sat(c - c0 - 1);
    ex_st[c]    = m;
    ex_tl[c]    = tl;
  endfunction

  function automatic void fill_hold(input int a, input int z);
    for (int c = a; c <= z; c++) begin
      ex_stage[c] = h_stage;
      ex_err[c]   = h_err;
      ex_cc[c]    = h_cc;
      ex_st[c]    = '0;
      ex_tl[c]    = 1'b0;
    end
  endfunction

  // Per-run stub behaviour: random, with directed runs first.
  task automatic cfg(input int r);
    force_sp = (r == 2);
    for (int b = 0; b < NB; b++) begin
      dly[b]  = int'($urandom_range(1, TMO));
      lvl[b]  = ($urandom_range(0, 1) == 1);
      hold[b] = int'($urandom_range(0, 30));
      if ($urandom_range(0, 24) == 0) dly[b] = 99;
      if (r <= 4) begin
        dly[b] = (r == 3) ? 2 : 3;
        lvl[b] = 1'b0;
      end
    end
    case (r)
      0: begin
        dly[2] = 5;
        dly[3] = 7;
      end
      1: begin
        dly[3]  = 2;
        dly[1]  = 6;
        dly[2]  = 6;
        lvl[2]  = 1'b1;
        hold[2] = 15;
        lvl[4]  = 1'b1;
        hold[4] = 80;
      end
      3: dly[6] = 99;
      default: ;
    endcase
  endtask

  // One run from edge cycle c0: stage n lasts until its last done,
  // or TIMEOUT waiting cycles, then the next stage begins.
  task automatic run_at(input int c0, output int endc);
    int e;
    int last;
    int comp;
    int cb;
    int code;
    int ob;
    bit to;
    e = c0 + 1;
    code = 0;
    to = 1'b0;
    for (int s = 1; s <= 7 && !to; s++) begin
      ent[s] = e;
      if (s == 6) begin
        for (int c = e; c < e + FC; c++) wr(c, c0, 6, '0, 1'b1);
        e += FC;
      end else begin
        comp = e;
        for (int b = blo(s); b <= bhi(s); b++) begin
          if (dly[b] <= TMO) begin
            if (lvl[b]) begin
              for (int k = 0; k <= hold[b]; k++)
                put(b, e + dly[b] + k);
            end else begin
              put(b, e + dly[b]);
            end
          end
          cb = -1;
          for (int c = e + TMO; c > e; c--)
            if (wave[b][c]) cb = c;
          if (cb < 0) to = 1'b1;
          else if (cb > comp) comp = cb;
        end
        last = to ? e + TMO : comp;
        for (int c = e; c <= last; c++)
          wr(c, c0, s, (c == e) ? mask(s) : '0, 1'b0);
        if (to) code = s;
        ob = int'($urandom_range(0, NB - 1));
        if ((ob < blo(s) || ob > bhi(s)) &&
            $urandom_range(0, 2) == 0)
          put(ob, e + int'($urandom_range(0, last - e)));
        if (s == 4 && force_sp) put(7, e + 1);
        e = last + 1;
      end
    end
    endc    = e;
    h_stage = to ? 4'hF : 4'h8;
    h_err   = 4'(code);
    h_cc    = sat(e - c0 - 1);
  endtask

  task automatic build();
    int c0;
    int endc;
    int r;
    int g;
    int runs;
    bit l;
    bit rs;
    h_stage = 4'd0;
    h_err   = 4'd0;
    h_cc    = 0;
    in_start[0] = 1'b1;
    c0 = 0;
    fill_hold(0, 0);
    runs = 0;
    while (c0 < NMAX - 300 && runs < 14) begin
      cfg(runs);
      run_at(c0, endc);
      rs = (runs == 4) ||
           (runs > 4 && $urandom_range(0, 4) == 0);
      if (rs) begin
        r = (runs == 4) ? ent[4] + 1 :
            c0 + 1 + int'($urandom_range(0, endc - c0 - 2));
        in_rst[r] = 1'b1;
        endc = r + 1;
        h_stage = 4'd0;
        h_err = 4'd0;
        h_cc = 0;
      end
      for (int c = c0 + 1; c < endc; c++)
        in_start[c] = (runs == 0) ? 1'b1 :
                      ($urandom_range(0, 1) == 1);
      g = int'($urandom_range(1, 4));
      l = in_start[endc - 1];
      for (int c = endc; c < endc + g; c++) begin
        in_start[c] = l;
        if ($urandom_range(0, 2) == 0)
          put(int'($urandom_range(0, NB - 1)), c);
      end
      in_start[endc + g] = !l;
      in_start[endc + g + 1] = 1'b1;
      c0 = endc;
      while (!is_edge(c0)) c0++;
      fill_hold(endc, c0);
      runs++;
    end
    n_cyc = c0 + 1;
  endtask

  initial begin
    build();
    reset = 1'b1;
    start_keygen = 1'b1;
    dn = '0;
    repeat (3) @(posedge clock);
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clock);
      cur = c;
      chk("stage", 32'(stage), 32'(ex_stage[c]));
      chk("status", 32'({busy, done_keygen, error, t_load_en}),
          32'({(ex_stage[c] >= 4'd1 && ex_stage[c] <= 4'd7),
               (ex_stage[c] == 4'd8),
               (ex_stage[c] == 4'd15),
               ex_tl[c]}));
      chk("starts", 32'(st), 32'(ex_st[c]));
      chk("cycle_count", 32'(cycle_count), 32'(ex_cc[c]));
      chk("err_stage", 32'(err_stage), 32'(ex_err[c]));
      case (c)
        0:  chk("reset_stage", 32'(stage), 32'd0);
        4:  chk("nom_shake1_end", 32'(stage), 32'd1);
        5:  chk("nom_expand_in", 32'(stage), 32'd2);
        12: chk("nom_expand_end", 32'(stage), 32'd2);
        13: chk("nom_ntt_in", 32'(stage), 32'd3);
        25: chk("nom_tload", 32'(t_load_en), 32'd1);
        27: chk("nom_shake2_in", 32'(st), 32'h80);
        31: begin
          chk("nom_done", 32'(done_keygen), 32'd1);
          chk("nom_count", 32'(cycle_count), 32'd30);
        end
        default: ;
      endcase
      reset = in_rst[c];
      start_keygen = in_start[c];
      for (int b = 0; b < NB; b++) dn[b] = wave[b][c];
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
